sha3_multirate_padder: RTL and testbench
========================================

Name: sha3_multirate_padder

Overview:
Multi-mode successor to the fixed SHA3-512 input padder. It accepts a byte-oriented 64-bit word stream and assembles rate-sized blocks for SHA3-224, SHA3-256, SHA3-384 or SHA3-512, with the mode selected per message. It applies pad10*1 using a configurable domain-separation byte and hands each block to the Keccak-f[1600] core through a valid/ack handshake. It sits between the bus-side message feeder and the permutation core in the SHA3 top level.

Parameters:
DEFAULT_MODE, 2'd3, mode in effect after reset until the first ISTART (3 = SHA3-512).
DS_BYTE, 8'h06, domain-separation byte (8'h1F for SHAKE use).
MAX_WORDS, 18, block buffer depth in 64-bit words; fixed by the widest rate, not user-tunable.

Ports:
ICLK  in  1  clock, rising edge
IRST_N  in  1  asynchronous active-low reset
ISTART  in  1  synchronous message start; clears the block and latches IMODE
IMODE  in  2  0=224 (R=18 words), 1=256 (R=17), 2=384 (R=13), 3=512 (R=9)
IDATA  in  64  message word; first byte in [63:56]
IREADY  in  1  IDATA valid
ILAST  in  1  IDATA is the final word of the message
IBYTE_NUM  in  3  valid bytes in the final word (0..7); ignored unless ILAST
OBUFFER_FULL  out  1  word not accepted this cycle
OBLOCK  out  1152  block; word k at [1151-64k -: 64]; words >= R read 0
OBLOCK_VALID  out  1  OBLOCK is complete
OLAST_BLOCK  out  1  qualifies OBLOCK_VALID; final block of the message
IBLOCK_ACK  in  1  core has consumed OBLOCK

Behaviour:
- Async reset: state ACCUM, cnt=0, buffer=0, mode=DEFAULT_MODE. All outputs 0.
- ISTART (sync) has highest priority. It sets ACCUM, cnt=0 and buffer=0, latches IMODE, and drops VALID. Any IREADY in the same cycle is discarded. IMODE is ignored at all other times.
- States: ACCUM, EMIT, DONE.
- ACCUM:
  - OBUFFER_FULL=0. A word is accepted on a rising edge with IREADY=1.
  - Non-last word: written to buf[cnt], cnt++.
  - When the word written is at cnt=R-1: go to EMIT with OLAST_BLOCK=0.
- Last word (ILAST=1), accepted in ACCUM:
  - Bytes 0..b-1 are taken from IDATA, where b=IBYTE_NUM.
  - Byte b = DS_BYTE; remaining bytes = 0.
  - Words cnt+1..R-1 are zeroed.
  - The LSB byte of word R-1 is ORed with 8'h80. If b=7 and cnt=R-1 these coincide, giving DS_BYTE|8'h80 (e.g. 8'h86).
  - b=0 consumes no data; the word contains only padding.
  - Go to EMIT with OLAST_BLOCK=1.
  - A last word always fits, so no extra padding block is ever generated.
- EMIT:
  - OBLOCK_VALID=1 and OBUFFER_FULL=1. OBLOCK is held stable until IBLOCK_ACK.
  - VALID rises the cycle after the accepting edge.
  - ACK may be high in the first VALID cycle.
  - On ACK with not-last: go to ACCUM, cnt=0, buffer cleared; the next word is accepted the cycle after ACK.
  - On ACK with last: go to DONE.
- DONE:
  - OBUFFER_FULL=0, but IREADY/ILAST are silently discarded until ISTART.
  - OBLOCK_VALID=0; OBLOCK keeps the last block.
- Throughput: R accept cycles + 1 cycle minimum per block.
- Mode change takes effect only at ISTART; it never alters an in-flight block.

Decomposition:
- Package sha3_pad_pkg:
  - mode encodings;
  - rate_words(mode) function (18/17/13/9);
  - MAX_WORDS=18;
  - PAD_END=8'h80;
  - state encoding.
- Sub-module sha3_pad_lastword: combinational. Takes IDATA, b, DS_BYTE and an is_final_word flag, and produces the padded 64-bit word.

Test Plan:
1. Mode 3, empty message (ILAST, b=0, IDATA=64'h12345678).
   -> Word0=0600000000000000, word8=0000000000000080, others 0, OLAST_BLOCK=1.
   -> The second ILAST offered the next cycle is discarded; after ACK, OBUFFER_FULL stays 0.
2. Mode 0, "dog" (IDATA=646F670000000000, b=3).
   -> Word0=646F670600000000, word17=0000000000000080, words 1..16=0, words beyond 17=0.
3. Mode 3, 8 words of EFCDAB9078563412, then ILAST b=7 with the same word.
   -> Word8=EFCDAB9078563486, OLAST_BLOCK=1.
4. Mode 1, 17 full words, ILAST=0.
   -> VALID the next cycle with OLAST_BLOCK=0; OBUFFER_FULL=1.
   -> Hold ACK low 3 cycles: word 18 is not accepted and OBLOCK is stable.
   -> After ACK, word 18 lands in word0 of a cleared block.
5. Mode 2: 5 words, then ISTART with IMODE=3, then 9 words.
   -> The first 5 words are lost; the block emits after exactly 9 words with words 9..17=0.
6. IRST_N low during EMIT.
   -> VALID, OLAST_BLOCK, OBUFFER_FULL and OBLOCK read 0 immediately (asynchronously); mode reverts to DEFAULT_MODE.

Source files
------------

// File: rtl/sha3_pad_pkg.sv
// Shared constants, encodings and the rate lookup for the multi-rate SHA3 padder.
package sha3_pad_pkg;

  localparam int          MAX_WORDS = 18;
  localparam logic [7:0]  PAD_END   = 8'h80;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Rate in 64-bit words for each SHA3 output size.
  function automatic logic [4:0] rate_words(input logic [1:0] mode);
    case (mode)
      MODE_224: rate_words = 5'd18;
      MODE_256: rate_words = 5'd17;
      MODE_384: rate_words = 5'd13;
      default:  rate_words = 5'd9;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_lastword.sv
// Pads the final message word: keeps the first b bytes, inserts the
// domain-separation byte at position b and zeroes the rest.
module sha3_pad_lastword (
  input  logic [63:0] data,
  input  logic [2:0]  byteNum,
  input  logic [7:0]  dsByte,
  input  logic        isFinal,
  output logic [63:0] padded
);

  // Byte 0 sits in [63:56]; non-final words pass through untouched.
  always_comb begin
    padded = data;
    if (isFinal) begin
      for (int i = 0; i < 8; i++) begin
        if (3'(i) == byteNum)      padded[63-8*i -: 8] = dsByte;
        else if (3'(i) > byteNum)  padded[63-8*i -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha3_multirate_padder.sv
// Multi-rate SHA3 input padder: gathers 64-bit words into rate-sized blocks,
// applies pad10*1 on the last word and hands blocks over a valid/ack handshake.
module sha3_multirate_padder
  import sha3_pad_pkg::*;
#(
  parameter logic [1:0] DEFAULT_MODE = 2'd3,
  parameter logic [7:0] DS_BYTE      = 8'h06
) (
  input  logic          ICLK,
  input  logic          IRST_N,
  input  logic          ISTART,
  input  logic [1:0]    IMODE,
  input  logic [63:0]   IDATA,
  input  logic          IREADY,
  input  logic          ILAST,
  input  logic [2:0]    IBYTE_NUM,
  output logic          OBUFFER_FULL,
  output logic [1151:0] OBLOCK,
  output logic          OBLOCK_VALID,
  output logic          OLAST_BLOCK,
  input  logic          IBLOCK_ACK
);

  state_e                         state, stateNext;
  logic [4:0]                     cnt;
  logic [1:0]                     mode;
  logic                           lastBlk;
  logic [MAX_WORDS-1:0][63:0]     blockBuf, bufNext;
  logic [63:0]                    padWord;
  logic [4:0]                     rateM1;
  logic                           accept;

  assign rateM1 = rate_words(mode) - 5'd1;
  // ISTART wins over any word presented in the same cycle.
  assign accept = (state == ST_ACCUM) && IREADY && !ISTART;

  sha3_pad_lastword uLastWord (
    .data    (IDATA),
    .byteNum (IBYTE_NUM),
    .dsByte  (DS_BYTE),
    .isFinal (ILAST),
    .padded  (padWord)
  );

  // Buffer image after accepting the current word. Words beyond cnt are
  // already zero because the buffer is cleared whenever a block starts.
  always_comb begin
    bufNext = blockBuf;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (5'(k) == cnt) bufNext[k] = padWord;
      if (ILAST && 5'(k) == rateM1) bufNext[k][7:0] = bufNext[k][7:0] | PAD_END;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    if (ISTART) begin
      stateNext = ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM: if (accept && (ILAST || cnt == rateM1)) stateNext = ST_EMIT;
        ST_EMIT:  if (IBLOCK_ACK) stateNext = lastBlk ? ST_DONE : ST_ACCUM;
        default:  stateNext = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge ICLK or negedge IRST_N) begin
    if (!IRST_N) state <= ST_ACCUM;
    else         state <= stateNext;
  end

  // Block buffer, word counter, latched mode and last-block flag.
  always_ff @(posedge ICLK or negedge IRST_N) begin
    if (!IRST_N) begin
      blockBuf <= '0;
      cnt      <= '0;
      mode     <= DEFAULT_MODE;
      lastBlk  <= 1'b0;
    end else if (ISTART) begin
      blockBuf <= '0;
      cnt      <= '0;
      mode     <= IMODE;
      lastBlk  <= 1'b0;
    end else if (accept) begin
      blockBuf <= bufNext;
      cnt      <= cnt + 5'd1;
      lastBlk  <= ILAST;
    end else if (state == ST_EMIT && IBLOCK_ACK && !lastBlk) begin
      blockBuf <= '0;
      cnt      <= '0;
    end
  end

  // Word k of the block occupies the k-th 64-bit slice from the top.
  for (genvar k = 0; k < MAX_WORDS; k++) begin : gWord
    assign OBLOCK[1151-64*k -: 64] = blockBuf[k];
  end

  assign OBLOCK_VALID = (state == ST_EMIT);
  assign OBUFFER_FULL = (state == ST_EMIT);
  assign OLAST_BLOCK  = (state == ST_EMIT) && lastBlk;

endmodule

// File: tb/tb_sha3_multirate_padder.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized messages checked against a byte-level pad10*1 model.
module tb_sha3_multirate_padder;

  localparam logic [7:0] DS = 8'h06;

  logic          ICLK = 1'b0;
  logic          IRST_N = 1'b0;
  logic          ISTART = 1'b0;
  logic [1:0]    IMODE = 2'd0;
  logic [63:0]   IDATA = '0;
  logic          IREADY = 1'b0;
  logic          ILAST = 1'b0;
  logic [2:0]    IBYTE_NUM = '0;
  logic          OBUFFER_FULL;
  logic [1151:0] OBLOCK;
  logic          OBLOCK_VALID;
  logic          OLAST_BLOCK;
  logic          IBLOCK_ACK = 1'b0;

  int nChecks = 0;
  int nFail   = 0;

  sha3_multirate_padder dut (
    .ICLK         (ICLK),
    .IRST_N       (IRST_N),
    .ISTART       (ISTART),
    .IMODE        (IMODE),
    .IDATA        (IDATA),
    .IREADY       (IREADY),
    .ILAST        (ILAST),
    .IBYTE_NUM    (IBYTE_NUM),
    .OBUFFER_FULL (OBUFFER_FULL),
    .OBLOCK       (OBLOCK),
    .OBLOCK_VALID (OBLOCK_VALID),
    .OLAST_BLOCK  (OLAST_BLOCK),
    .IBLOCK_ACK   (IBLOCK_ACK)
  );

  always #5 ICLK = ~ICLK;

  function automatic int rateOf(input logic [1:0] m);
    case (m)
      2'd0: return 18;
      2'd1: return 17;
      2'd2: return 13;
      default: return 9;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkBlk(input string name, input logic [1151:0] exp);
    nChecks++;
    if (OBLOCK !== exp) begin
      nFail++;
      for (int k = 0; k < 18; k++)
        if (OBLOCK[1151-64*k -: 64] !== exp[1151-64*k -: 64]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, k,
                   OBLOCK[1151-64*k -: 64], exp[1151-64*k -: 64]);
          break;
        end
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic tick();
    @(negedge ICLK);
  endtask

  task automatic startMsg(input logic [1:0] m);
    ISTART = 1'b1; IMODE = m;
    tick();
    ISTART = 1'b0; IMODE = 2'd0;
  endtask

  task automatic sendWord(input logic [63:0] d, input logic last, input logic [2:0] b);
    IREADY = 1'b1; IDATA = d; ILAST = last; IBYTE_NUM = b;
    tick();
    IREADY = 1'b0; ILAST = 1'b0; IBYTE_NUM = '0; IDATA = '0;
  endtask

  task automatic ackOnce();
    IBLOCK_ACK = 1'b1;
    tick();
    IBLOCK_ACK = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          nFull;
    logic [63:0] fullData;
    logic [63:0] lastData;
    logic [2:0]  b;
    logic [63:0] expWord;
    logic [63:0] expTail;
  } vec_t;

  vec_t vecs[5];

  // Randomized message check against a byte-stream pad10*1 model.
  task automatic randMsg(input int id);
    logic [1:0]    m;
    int            nFull, r, nBlk, blk, idx, budget;
    logic [2:0]    b;
    logic [63:0]   words[$];
    logic [7:0]    q[$];
    logic [1151:0] expBlks[$];
    logic [1151:0] e;
    logic          offered, acked;
    m = 2'($urandom_range(0, 3));
    r = rateOf(m);
    nFull = $urandom_range(0, 40);
    b = 3'($urandom_range(0, 7));
    words = {};
    for (int i = 0; i <= nFull; i++) words.push_back({$urandom, $urandom});
    q = {};
    for (int i = 0; i < nFull; i++)
      for (int j = 0; j < 8; j++) q.push_back(words[i][63-8*j -: 8]);
    for (int j = 0; j < int'(b); j++) q.push_back(words[nFull][63-8*j -: 8]);
    q.push_back(DS);
    while (q.size() % (8*r) != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    nBlk = q.size() / (8*r);
    expBlks = {};
    for (int j = 0; j < nBlk; j++) begin
      e = '0;
      for (int p = 0; p < 8*r; p++) e[1151-8*p -: 8] = q[j*8*r + p];
      expBlks.push_back(e);
    end

    startMsg(m);
    blk = 0; idx = 0; budget = 0;
    while (blk < nBlk) begin
      if (budget++ > 2000) begin
        nChecks++; nFail++;
        $display("FAIL rand%0d timeout: blocks seen %0d expected %0d", id, blk, nBlk);
        break;
      end
      offered = 1'b0; acked = 1'b0;
      if (OBLOCK_VALID) begin
        chkBlk($sformatf("rand%0d blk%0d", id, blk), expBlks[blk]);
        chk($sformatf("rand%0d last%0d", id, blk), 64'(OLAST_BLOCK), 64'(blk == nBlk-1));
        acked = ($urandom_range(0, 2) == 0);
        IBLOCK_ACK = acked;
        IREADY = $urandom_range(0, 1);
        IDATA = {$urandom, $urandom}; ILAST = $urandom_range(0, 1);
      end else begin
        offered = (idx <= nFull) && ($urandom_range(0, 3) != 0) && !OBUFFER_FULL;
        IREADY = offered;
        IDATA = (idx <= nFull) ? words[idx] : '0;
        ILAST = (idx == nFull);
        IBYTE_NUM = (idx == nFull) ? b : 3'($urandom_range(0, 7));
      end
      tick();
      IREADY = 1'b0; ILAST = 1'b0; IBLOCK_ACK = 1'b0;
      if (offered) idx++;
      if (acked) blk++;
    end
    chk($sformatf("rand%0d done valid", id), 64'(OBLOCK_VALID), 64'd0);
  endtask

  initial begin
    logic [1151:0] e, held;
    logic [63:0]   w[$];
    int            r;

    vecs[0] = '{2'd3, 0,  64'h0, 64'h0000000012345678, 3'd0, 64'h0600000000000000, 64'h80};
    vecs[1] = '{2'd0, 0,  64'h0, 64'h646F670000000000, 3'd3, 64'h646F670600000000, 64'h80};
    vecs[2] = '{2'd3, 8,  64'hEFCDAB9078563412, 64'hEFCDAB9078563412, 3'd7,
                64'hEFCDAB9078563486, 64'hEFCDAB9078563486};
    vecs[3] = '{2'd1, 16, 64'h1111111111111111, 64'h0102030405060708, 3'd7,
                64'h0102030405060786, 64'h0102030405060786};
    vecs[4] = '{2'd2, 3,  64'h2222222222222222, 64'hAABBCCDD11223344, 3'd4,
                64'hAABBCCDD06000000, 64'h80};

    // Reset state.
    tick(); tick();
    chk("rst valid", 64'(OBLOCK_VALID), 64'd0);
    chk("rst full",  64'(OBUFFER_FULL), 64'd0);
    chk("rst last",  64'(OLAST_BLOCK),  64'd0);
    chkBlk("rst block", '0);
    IRST_N = 1'b1;
    tick();

    // Table-driven single-block messages.
    for (int v = 0; v < 5; v++) begin
      r = rateOf(vecs[v].mode);
      e = '0;
      for (int k = 0; k < vecs[v].nFull; k++) e[1151-64*k -: 64] = vecs[v].fullData;
      e[1151-64*vecs[v].nFull -: 64] = vecs[v].expWord;
      e[1151-64*(r-1) -: 64] = vecs[v].expTail;
      startMsg(vecs[v].mode);
      for (int k = 0; k < vecs[v].nFull; k++) sendWord(vecs[v].fullData, 1'b0, 3'd0);
      sendWord(vecs[v].lastData, 1'b1, vecs[v].b);
      chk($sformatf("vec%0d valid", v), 64'(OBLOCK_VALID), 64'd1);
      chk($sformatf("vec%0d last", v),  64'(OLAST_BLOCK),  64'd1);
      chk($sformatf("vec%0d full", v),  64'(OBUFFER_FULL), 64'd1);
      chkBlk($sformatf("vec%0d block", v), e);
      sendWord(64'hDEADBEEFDEADBEEF, 1'b1, 3'd5);
      chkBlk($sformatf("vec%0d emit hold", v), e);
      ackOnce();
      chk($sformatf("vec%0d done valid", v), 64'(OBLOCK_VALID), 64'd0);
      chk($sformatf("vec%0d done full", v),  64'(OBUFFER_FULL), 64'd0);
      sendWord(64'hCAFEF00DCAFEF00D, 1'b1, 3'd2);
      chk($sformatf("vec%0d done ignore", v), 64'(OBLOCK_VALID), 64'd0);
      chk($sformatf("vec%0d done full2", v), 64'(OBUFFER_FULL), 64'd0);
      chkBlk($sformatf("vec%0d done keep", v), e);
    end

    // Mode 1: 17 full words, back-pressure, then the next word after ACK.
    startMsg(2'd1);
    w = {};
    e = '0;
    for (int k = 0; k < 18; k++) w.push_back({$urandom, $urandom});
    for (int k = 0; k < 17; k++) begin
      sendWord(w[k], 1'b0, 3'd0);
      e[1151-64*k -: 64] = w[k];
    end
    chk("m1 valid", 64'(OBLOCK_VALID), 64'd1);
    chk("m1 last",  64'(OLAST_BLOCK),  64'd0);
    chk("m1 full",  64'(OBUFFER_FULL), 64'd1);
    chkBlk("m1 block", e);
    IREADY = 1'b1; IDATA = w[17]; ILAST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chkBlk($sformatf("m1 stable%0d", c), e);
      chk($sformatf("m1 hold valid%0d", c), 64'(OBLOCK_VALID), 64'd1);
    end
    IBLOCK_ACK = 1'b1;
    tick();
    IBLOCK_ACK = 1'b0;
    chk("m1 post-ack full", 64'(OBUFFER_FULL), 64'd0);
    chkBlk("m1 cleared", '0);
    tick();
    IREADY = 1'b0;
    e = '0;
    e[1151 -: 64] = w[17];
    chk("m1 accum valid", 64'(OBLOCK_VALID), 64'd0);
    chkBlk("m1 word18", e);
    sendWord(64'h0, 1'b1, 3'd0);
    e[1151-64 -: 64] = 64'h0600000000000000;
    e[1151-64*16 -: 64] = 64'h80;
    chk("m1 tail last", 64'(OLAST_BLOCK), 64'd1);
    chkBlk("m1 tail block", e);
    ackOnce();

    // Mode 2 aborted by ISTART into mode 3.
    startMsg(2'd2);
    for (int k = 0; k < 5; k++) sendWord(64'hBAD0BAD0BAD0BAD0, 1'b0, 3'd0);
    startMsg(2'd3);
    e = '0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("abort pre%0d", k), 64'(OBLOCK_VALID), 64'd0);
      sendWord(64'h0101010101010101 * 64'(k + 1), 1'b0, 3'd0);
      e[1151-64*k -: 64] = 64'h0101010101010101 * 64'(k + 1);
    end
    chk("abort valid", 64'(OBLOCK_VALID), 64'd1);
    chk("abort last",  64'(OLAST_BLOCK),  64'd0);
    chkBlk("abort block", e);
    ackOnce();

    // Asynchronous reset during EMIT, then default mode (R=9) applies.
    startMsg(2'd0);
    for (int k = 0; k < 17; k++) sendWord(64'h5555AAAA5555AAAA, 1'b0, 3'd0);
    sendWord(64'h77, 1'b1, 3'd7);
    chk("arst pre valid", 64'(OBLOCK_VALID), 64'd1);
    #2 IRST_N = 1'b0;
    #1;
    chk("arst valid", 64'(OBLOCK_VALID), 64'd0);
    chk("arst last",  64'(OLAST_BLOCK),  64'd0);
    chk("arst full",  64'(OBUFFER_FULL), 64'd0);
    chkBlk("arst block", '0);
    tick();
    IRST_N = 1'b1;
    tick();
    e = '0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("dflt pre%0d", k), 64'(OBLOCK_VALID), 64'd0);
      sendWord(64'hF0F0F0F000000000 + 64'(k), 1'b0, 3'd0);
      e[1151-64*k -: 64] = 64'hF0F0F0F000000000 + 64'(k);
    end
    chk("dflt valid", 64'(OBLOCK_VALID), 64'd1);
    chkBlk("dflt block", e);
    ackOnce();

    // Randomized multi-block messages.
    for (int i = 0; i < 30; i++) randMsg(i);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
